// File: rtl/mul_pkg.sv
// Shared types and constants for the multiplier job sequencer.
package mul_pkg;
  localparam int MUL_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // A timed-out job reports a product of all ones.
  localparam logic TIMEOUT_FILL = 1'b1;
endpackage

// File: rtl/mul_operand_fifo.sv
// Operand-pair FIFO. Pointers carry one extra bit so that full and empty
// can be told apart when the index bits match.
module mul_operand_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/mul_job_ctrl.sv
// Sequencer in front of the sequential multiplier: buffers operand pairs,
// issues one job at a time, and presents each product over valid/ready.
//
//   state | meaning
//   IDLE  | nothing in flight; pop the FIFO head when one is present
//   ISSUE | mul_start pulse, watchdog armed
//   WAIT  | operands held, waiting for mul_done or watchdog expiry
//   HOLD  | out_valid high until out_ready; may pop the next job in the accept cycle
module mul_job_ctrl
  import mul_pkg::*;
#(
  parameter int W          = MUL_W,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_multiplicand,
  input  logic [W-1:0]   in_multiplier,
  output logic           mul_start,
  output logic [W-1:0]   mul_multiplicand,
  output logic [W-1:0]   mul_multiplier,
  input  logic           mul_done,
  input  logic [2*W-1:0] mul_product,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_product,
  output logic           busy,
  output logic           timeout_err
);
  localparam int CW = $clog2(TIMEOUT);

  state_t          state;
  logic [CW-1:0]   wd_cnt;
  logic            rdy_en;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  logic            head_zero;
  logic [2*W-1:0]  fifo_head;

  // rdy_en keeps in_ready low while reset is asserted.
  assign in_ready  = rdy_en && !fifo_full;
  assign fifo_pop  = !fifo_empty && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign head_zero = (fifo_head[2*W-1:W] == '0) || (fifo_head[W-1:0] == '0);
  assign busy      = (state != IDLE) || !fifo_empty;

  mul_operand_fifo #(
    .DW    (2*W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && in_ready),
    .push_data ({in_multiplicand, in_multiplier}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      wd_cnt           <= '0;
      rdy_en           <= 1'b0;
      mul_start        <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      out_valid        <= 1'b0;
      out_product      <= '0;
      timeout_err      <= 1'b0;
    end else begin
      rdy_en    <= 1'b1;
      mul_start <= 1'b0;
      if (fifo_pop) begin
        mul_multiplicand <= fifo_head[2*W-1:W];
        mul_multiplier   <= fifo_head[W-1:0];
      end
      case (state)
        IDLE, HOLD: begin
          // IDLE and an accepted HOLD share the pop/evaluate path.
          if ((state == IDLE) || out_ready) begin
            out_valid <= 1'b0;
            if (fifo_pop) begin
              if (head_zero) begin
                out_product <= '0;
                out_valid   <= 1'b1;
                state       <= HOLD;
              end else begin
                mul_start <= 1'b1;
                state     <= ISSUE;
              end
            end else begin
              state <= IDLE;
            end
          end
        end
        ISSUE: begin
          wd_cnt <= CW'(TIMEOUT - 1);
          state  <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            out_product <= mul_product;
            out_valid   <= 1'b1;
            state       <= HOLD;
          end else if (wd_cnt == '0) begin
            timeout_err <= 1'b1;
            out_product <= {(2*W){TIMEOUT_FILL}};
            out_valid   <= 1'b1;
            state       <= HOLD;
          end else begin
            wd_cnt <= wd_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_job_ctrl.sv
// Scenario bench for mul_job_ctrl with a behavioural multiplier and an
// expected-product scoreboard drained by an output monitor.
`timescale 1ns/1ps
module tb_mul_job_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_multiplicand = '0;
  logic [15:0] in_multiplier = '0;
  logic        mul_start;
  logic [15:0] mul_multiplicand;
  logic [15:0] mul_multiplier;
  logic        mul_done;
  logic [31:0] mul_product = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_product;
  logic        busy;
  logic        timeout_err;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int          start_cnt = 0;
  int          rx_cnt = 0;
  int          mul_lat = 16;
  logic        model_done = 1'b0;
  logic        stray_done = 1'b0;

  assign mul_done = model_done | stray_done;

  always #5 clk = ~clk;

  mul_job_ctrl #(.W(16), .FIFO_DEPTH(2), .TIMEOUT(64)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_multiplicand  (in_multiplicand),
    .in_multiplier    (in_multiplier),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_done         (mul_done),
    .mul_product      (mul_product),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_product      (out_product),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  // Multiplier model: done arrives mul_lat cycles after the start cycle; mul_lat=0 never answers.
  initial begin
    logic [31:0] p;
    forever begin
      @(negedge clk);
      if (mul_start && mul_lat > 0) begin
        p = {16'b0, mul_multiplicand} * {16'b0, mul_multiplier};
        repeat (mul_lat) @(posedge clk);
        #1;
        model_done  = 1'b1;
        mul_product = p;
        @(posedge clk);
        #1;
        model_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mul_start) start_cnt++;
      if (out_valid && out_ready) begin
        rx_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got %h, none expected", out_product);
        end else begin
          mon_exp = exp_q.pop_front();
          if (out_product !== mon_exp) begin
            failures++;
            $display("FAIL product: got %h, required %h", out_product, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  // Call at posedge+1; returns at posedge+1 of the cycle after the handshake.
  task automatic push_pair(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    int n;
    bit done;
    n = 0;
    done = 0;
    in_multiplicand = a;
    in_multiplier   = b;
    in_valid        = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        done = 1;
      end else if (++n > 500) begin
        checks++;
        failures++;
        $display("FAIL push_stall: in_ready=%b, required 1 within 500 cycles", in_ready);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic accept_one();
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({mul_start, mul_multiplicand, mul_multiplier, out_valid, out_product, busy, timeout_err, in_ready} !== '0) begin
      failures++;
      $display("FAIL reset_values: start=%b a=%h b=%h ov=%b prod=%h busy=%b terr=%b rdy=%b, required all 0",
               mul_start, mul_multiplicand, mul_multiplier, out_valid, out_product, busy, timeout_err, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: got %b, required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int s0;
    int n;
    mul_lat = 16;
    out_ready = 1'b0;
    s0 = start_cnt;
    push_pair(16'h0082, 16'h0004, 32'h00000208);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    checks++;
    if (n != 19) begin
      failures++;
      $display("FAIL basic_latency: out_valid after %0d cycles, required 19", n);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_product !== 32'h00000208) begin
      failures++;
      $display("FAIL basic_hold: ov=%b prod=%h, required 1 00000208", out_valid, out_product);
    end
    accept_one();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || (start_cnt - s0) != 1) begin
      failures++;
      $display("FAIL basic_after_accept: ov=%b starts=%0d, required 0 and 1", out_valid, start_cnt - s0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bypass();
    int s0;
    s0 = start_cnt;
    out_ready = 1'b0;
    push_pair(16'h0003, 16'h0000, 32'h0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bypass_early: out_valid=%b one cycle after push, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_product !== 32'h0 || (start_cnt - s0) != 0) begin
      failures++;
      $display("FAIL bypass_result: ov=%b prod=%h starts=%0d, required 1 0 0", out_valid, out_product, start_cnt - s0);
    end
    accept_one();
  endtask

  task automatic test_backpressure();
    int n;
    int r0;
    mul_lat = 16;
    out_ready = 1'b0;
    r0 = rx_cnt;
    push_pair(16'd3, 16'd2, 32'd6);
    push_pair(16'd5, 16'd7, 32'd35);
    push_pair(16'd0, 16'd9, 32'd0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready: in_ready=%b with FIFO full, required 0", in_ready);
    end
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_full: ov=%b rdy=%b, required 1 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_pair(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    drain();
    out_ready = 1'b0;
    checks++;
    if ((rx_cnt - r0) != 4) begin
      failures++;
      $display("FAIL backpressure_count: got %0d results, required 4", rx_cnt - r0);
    end
  endtask

  task automatic test_timeout();
    int n;
    mul_lat = 0;
    out_ready = 1'b0;
    push_pair(16'd5, 16'd5, 32'hFFFFFFFF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mul_start && n < 20);
    repeat (64) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early: timeout_err=%b after 64 WAIT cycles, required 0", timeout_err);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1 || out_valid !== 1'b1 || out_product !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL timeout_fire: terr=%b ov=%b prod=%h, required 1 1 ffffffff", timeout_err, out_valid, out_product);
    end
    accept_one();
    mul_lat = 16;
    out_ready = 1'b1;
    push_pair(16'd2, 16'd3, 32'd6);
    drain();
    out_ready = 1'b0;
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky: timeout_err=%b, required 1", timeout_err);
    end
  endtask

  task automatic test_reset_midjob();
    int n;
    bit bad;
    mul_lat = 0;
    out_ready = 1'b0;
    push_pair(16'd4, 16'd4, 32'd16);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mul_start && n < 20);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    checks++;
    if ({mul_start, mul_multiplicand, mul_multiplier, out_valid, out_product, busy, timeout_err, in_ready} !== '0) begin
      failures++;
      $display("FAIL midjob_reset: start=%b a=%h b=%h ov=%b prod=%h busy=%b terr=%b rdy=%b, required all 0",
               mul_start, mul_multiplicand, mul_multiplier, out_valid, out_product, busy, timeout_err, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midjob_ready: in_ready=%b in first cycle after release, required 1", in_ready);
    end
    @(posedge clk); #1;
    stray_done = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0 || mul_start !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL stray_done: ov/busy/start became active after stray done, required all 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int  acc;
    int  n;
    bit  pending;
    mul_lat = 4;
    out_ready = 1'b1;
    acc = 0;
    n = 0;
    pending = 0;
    fork
      begin
        logic [15:0] a;
        logic [15:0] b;
        for (int i = 0; i < 8; i++) begin
          a = 16'($urandom_range(1, 65535));
          b = 16'($urandom_range(1, 65535));
          push_pair(a, b, {16'b0, a} * {16'b0, b});
        end
      end
      begin
        while (acc < 8 && n < 3000) begin
          @(negedge clk);
          n++;
          if (pending) begin
            pending = 0;
            checks++;
            if (mul_start !== 1'b1) begin
              failures++;
              $display("FAIL b2b_start: mul_start=%b cycle after accept %0d, required 1", mul_start, acc);
            end
          end
          if (out_valid && out_ready) begin
            acc++;
            if (acc < 8) pending = 1;
          end
        end
      end
    join
    checks++;
    if (acc != 8) begin
      failures++;
      $display("FAIL b2b_count: got %0d results, required 8", acc);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_leftover: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_backpressure();
    test_timeout();
    test_reset_midjob();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
